// File: rtl/mem_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bist_pkg
//  Description : Shared definitions for the March C- memory BIST: controller
//                states, march element codes and per-element lookup tables
//                (address direction, expected read data, write data).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bist_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_ONLY = 3'd1,
        ST_RD     = 3'd2,
        ST_WR     = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_END    = 3'd5
    } bist_state_t;

    // March C- elements:
    // E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } march_elem_t;

    // Tables indexed by element code (bit n belongs to En, bits 7:6 unused)
    localparam logic [7:0] c_elem_up_tbl    = 8'b0010_0111; // 1 = ascending
    localparam logic [7:0] c_elem_rdata_tbl = 8'b0001_0100; // value expected on read
    localparam logic [7:0] c_elem_wdata_tbl = 8'b0000_1010; // value written

    function automatic logic elem_up(input march_elem_t e);
        return c_elem_up_tbl[e];
    endfunction

    function automatic logic elem_rdata(input march_elem_t e);
        return c_elem_rdata_tbl[e];
    endfunction

    function automatic logic elem_wdata(input march_elem_t e);
        return c_elem_wdata_tbl[e];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bist_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bist_addr_gen
//  Description : Up/down address counter with synchronous load, count enable
//                and a terminal-count flag for the current direction
//                (DEPTH-1 when counting up, 0 when counting down).
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_load/i_load_val - load a start address
//                i_en, i_up       - count enable and direction
//                o_addr           - current address
//                o_addr_nxt       - address after this clock edge
//                o_tc             - current address is terminal for i_up
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bist_addr_gen #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_en,
    input  logic              i_up,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_addr_nxt,
    output logic              o_tc
);

    localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    logic [ADDR_W-1:0] r_addr;

    always_comb begin
        o_addr_nxt = r_addr;
        if (i_load) begin
            o_addr_nxt = i_load_val;
        end else if (i_en) begin
            o_addr_nxt = i_up ? (r_addr + c_addr_one) : (r_addr - c_addr_one);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else begin
            r_addr <= o_addr_nxt;
        end
    end

    assign o_addr = r_addr;
    assign o_tc   = i_up ? (r_addr == c_addr_last) : (r_addr == '0);

endmodule
`default_nettype wire

// File: rtl/mem_bist_16384x1.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bist_16384x1
//  Description : March C- BIST controller for a DEPTHx1 synchronous memory.
//                Port 0 drives the test; port 1 is held inactive. Reads have
//                one cycle of latency, so each read is checked in the cycle
//                after it is issued; FLUSH covers the check of the last read.
//  Ports       : CLK, RSTN                    - clock, async active-low reset
//                START                        - begin a test (ignored if BUSY)
//                BUSY, DONE                   - running / finished (level)
//                FAIL, FAIL_ADDR, FAIL_ELEM   - sticky first-failure report
//                A0, D0, CE0, WE0, WEM0, Q0   - memory port 0
//                A1, D1, CE1, WE1, WEM1       - memory port 1 (tied off)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bist_16384x1
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [2:0]        FAIL_ELEM,
    output logic [ADDR_W-1:0] A0,
    output logic              D0,
    output logic              CE0,
    output logic              WE0,
    output logic              WEM0,
    input  logic              Q0,
    output logic [ADDR_W-1:0] A1,
    output logic              D1,
    output logic              CE1,
    output logic              WE1,
    output logic              WEM1
);

    localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(DEPTH - 1);

    bist_state_t       r_state, w_state_nxt;
    march_elem_t       r_elem, w_elem_nxt;
    logic              w_start;
    logic              w_addr_load, w_addr_en, w_tc;
    logic [ADDR_W-1:0] w_addr_ld_val, w_addr, w_addr_nxt;

    // Memory command registers (computed from next state so they line up
    // with the state that issues them)
    logic [ADDR_W-1:0] r_a0, w_a0_nxt;
    logic              r_d0, r_ce0, r_we0, r_wem0;
    logic              w_d0_nxt, w_ce0_nxt, w_we0_nxt, w_wem0_nxt;

    // Read-check pipeline and failure report
    logic              r_chk_vld, r_chk_exp;
    logic [ADDR_W-1:0] r_chk_addr;
    march_elem_t       r_chk_elem;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    march_elem_t       r_fail_elem;

    mem_bist_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk        (CLK),
        .rst_n      (RSTN),
        .i_load     (w_addr_load),
        .i_load_val (w_addr_ld_val),
        .i_en       (w_addr_en),
        .i_up       (elem_up(r_elem)),
        .o_addr     (w_addr),
        .o_addr_nxt (w_addr_nxt),
        .o_tc       (w_tc)
    );

    // Each element starts at the low end when ascending, high end otherwise
    assign w_addr_ld_val = elem_up(w_elem_nxt) ? '0 : c_addr_last;

    // ---------------------------------------------------------- state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_elem  <= E0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
        end
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_addr_load = 1'b0;
        w_addr_en   = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE, ST_END: begin
                if (START) begin
                    w_state_nxt = ST_W_ONLY;
                    w_elem_nxt  = E0;
                    w_addr_load = 1'b1;
                    w_start     = 1'b1;
                end
            end
            ST_W_ONLY: begin
                if (w_tc) begin
                    w_state_nxt = ST_RD;
                    w_elem_nxt  = E1;
                    w_addr_load = 1'b1;
                end else begin
                    w_addr_en = 1'b1;
                end
            end
            ST_RD: begin
                if (r_elem == E5) begin
                    if (w_tc) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_addr_en = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                w_state_nxt = ST_RD;
                if (w_tc) begin
                    w_elem_nxt  = march_elem_t'(r_elem + 3'd1);
                    w_addr_load = 1'b1;
                end else begin
                    w_addr_en = 1'b1;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_END;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- outputs
    always_comb begin
        w_ce0_nxt  = 1'b0;
        w_we0_nxt  = 1'b0;
        w_wem0_nxt = 1'b0;
        w_d0_nxt   = 1'b0;
        w_a0_nxt   = '0;
        case (w_state_nxt)
            ST_W_ONLY, ST_WR: begin
                w_ce0_nxt  = 1'b1;
                w_we0_nxt  = 1'b1;
                w_wem0_nxt = 1'b1;
                w_d0_nxt   = elem_wdata(w_elem_nxt);
                w_a0_nxt   = w_addr_nxt;
            end
            ST_RD: begin
                w_ce0_nxt = 1'b1;
                w_a0_nxt  = w_addr_nxt;
            end
            default: begin
                w_ce0_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_a0   <= '0;
            r_d0   <= 1'b0;
            r_ce0  <= 1'b0;
            r_we0  <= 1'b0;
            r_wem0 <= 1'b0;
        end else begin
            r_a0   <= w_a0_nxt;
            r_d0   <= w_d0_nxt;
            r_ce0  <= w_ce0_nxt;
            r_we0  <= w_we0_nxt;
            r_wem0 <= w_wem0_nxt;
        end
    end

    // ---------------------------------------------------------- read check
    // A read issued in RD returns on Q0 one cycle later; remember what it
    // should return so the compare happens in that following cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_chk_vld   <= 1'b0;
            r_chk_exp   <= 1'b0;
            r_chk_addr  <= '0;
            r_chk_elem  <= E0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= E0;
        end else begin
            r_chk_vld  <= (r_state == ST_RD);
            r_chk_exp  <= elem_rdata(r_elem);
            r_chk_addr <= w_addr;
            r_chk_elem <= r_elem;
            if (w_start) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_elem <= E0;
            end else if (r_chk_vld && (Q0 != r_chk_exp) && !r_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= r_chk_addr;
                r_fail_elem <= r_chk_elem;
            end
        end
    end

    assign BUSY      = (r_state == ST_W_ONLY) || (r_state == ST_RD) ||
                       (r_state == ST_WR)     || (r_state == ST_FLUSH);
    assign DONE      = (r_state == ST_END);
    assign FAIL      = r_fail;
    assign FAIL_ADDR = r_fail_addr;
    assign FAIL_ELEM = r_fail_elem;

    assign A0   = r_a0;
    assign D0   = r_d0;
    assign CE0  = r_ce0;
    assign WE0  = r_we0;
    assign WEM0 = r_wem0;

    assign A1   = '0;
    assign D1   = 1'b0;
    assign CE1  = 1'b0;
    assign WE1  = 1'b0;
    assign WEM1 = 1'b0;

endmodule
`default_nettype wire

// File: doc/mem_bist_16384x1.md
MEM_BIST_16384X1 -- requirements
Module: mem_bist_16384x1

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, address width of the memory under test.
REQ-002 SHALL have parameter DEPTH, default 16384, number of 1-bit words tested.
REQ-003 SHALL have ports: CLK in 1 clock; RSTN in 1 reset. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: START in 1 begin test; BUSY out 1 test running; DONE out 1 test finished (level); FAIL out 1 sticky mismatch; FAIL_ADDR out ADDR_W first failing address; FAIL_ELEM out 3 first failing march element.
REQ-005 SHALL have ports: A0 out ADDR_W; D0 out 1; CE0 out 1; WE0 out 1; WEM0 out 1; Q0 in 1 (memory port 0, initiator side).
REQ-006 SHALL have ports: A1 out ADDR_W; D1 out 1; CE1 out 1; WE1 out 1; WEM1 out 1 (port 1, held inactive).

Function
REQ-007 SHALL run March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-008 SHALL register all memory-side outputs; a read is CE0=1,WE0=0; a write is CE0=1,WE0=1,WEM0=1.
REQ-009 SHALL, in E1-E4, issue read then write to the same address on consecutive cycles, one address per 2 cycles.
REQ-010 SHALL compare Q0 against the expected bit in the cycle after the read command (1-cycle read latency, unregistered memory output).
REQ-011 SHALL use states IDLE, W_ONLY, RD, WR, FLUSH, END.
REQ-012 SHALL go IDLE/END -> W_ONLY on START=1; START while BUSY=1 SHALL be ignored.
REQ-013 SHALL go W_ONLY -> RD at the terminal address; RD -> WR always; WR -> RD (next address, or next element at the terminal address); RD in E5 -> RD at the next address, or -> FLUSH at address DEPTH-1; FLUSH -> END.
REQ-014 SHALL count up 0..DEPTH-1 and down DEPTH-1..0; the terminal address SHALL switch element with no wrap-around access.
REQ-015 SHALL take exactly 10*DEPTH command cycles plus 1 FLUSH cycle; DONE rises 10*DEPTH+1 cycles after BUSY rises.
REQ-016 SHALL assert BUSY in W_ONLY/RD/WR/FLUSH; DONE=1 only in END, held until the next START.
REQ-017 SHALL, on START, clear FAIL, FAIL_ADDR, FAIL_ELEM and DONE.
REQ-018 SHALL, on first mismatch, set FAIL and latch FAIL_ADDR/FAIL_ELEM; later mismatches SHALL NOT overwrite; the test SHALL run to completion.
REQ-019 SHALL drive CE0=0, WE0=0 in IDLE, FLUSH and END.
REQ-020 SHALL hold CE1, WE1, WEM1, D1, A1 at 0 at all times.

Reset
REQ-021 SHALL, on RSTN=0, immediately force state IDLE and all outputs to 0, including mid-test.
REQ-022 SHALL leave memory contents undefined after reset mid-test; a new START SHALL run a full test.

Structure
REQ-023 SHALL place the state enumeration, march element codes (E0-E5), per-element direction and expected-read/write-data tables in a shared package mem_bist_pkg.
REQ-024 SHALL use one sub-module, mem_bist_addr_gen: an up/down address counter with load, enable and terminal-count flag.

Verification
REQ-025 Fault-free 16384x1 model, 1-cycle START -> BUSY=1 next cycle; DONE=1 after 163841 cycles; FAIL=0.
REQ-026 Stuck-at-1 at 0x1234 -> FAIL=1, FAIL_ADDR=0x1234, FAIL_ELEM=1.
REQ-027 Stuck-at-0 at 0x3FFF -> FAIL=1, FAIL_ADDR=0x3FFF, FAIL_ELEM=2.
REQ-028 RSTN low for 2 cycles during E3 -> all outputs 0 in the same cycle; new START -> DONE after 163841 cycles.
REQ-029 START pulsed at cycle 5000 of a run -> ignored; DONE still at 163841; FAIL unchanged.
REQ-030 Whole run -> CE1=WE1=0 every cycle; no port-0 access outside 0..0x3FFF; no CE0=1 in FLUSH or END.
